// File: rtl/onchip_memory_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slave ports sharing one clock.
// Features: pipelined reads, cross-port write forwarding, s1-wins collisions, out-of-range masking.
module onchip_memory_dp #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 15,
  parameter int    DEPTH      = 32000,
  parameter int    OUTPUT_REG = 0,
  parameter string INIT_FILE  = "onchip_memory_dp.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic                    s1_waitrequest,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic                    s2_waitrequest,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int NP = 2;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic en;
  assign en             = clken & ~reset_req;
  assign s1_waitrequest = ~en;
  assign s2_waitrequest = ~en;

  // Index 0 is s1, index 1 is s2.
  logic [ADDR_WIDTH-1:0] addr  [NP];
  logic [NB-1:0]         be    [NP];
  logic [DATA_WIDTH-1:0] wdata [NP];
  logic [DATA_WIDTH-1:0] rdata [NP];
  logic [NP-1:0]         cs, wr, in_range, wr_ok, rd_ok, rvalid;

  assign addr[0]  = s1_address;
  assign addr[1]  = s2_address;
  assign be[0]    = s1_byteenable;
  assign be[1]    = s2_byteenable;
  assign wdata[0] = s1_writedata;
  assign wdata[1] = s2_writedata;
  assign cs       = {s2_chipselect, s1_chipselect};
  assign wr       = {s2_write, s1_write};

  assign s1_readdata      = rdata[0];
  assign s1_readdatavalid = rvalid[0];
  assign s2_readdata      = rdata[1];
  assign s2_readdatavalid = rvalid[1];

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_cmd
      assign in_range[gi] = ({1'b0, addr[gi]} < DEPTH_L);
      assign wr_ok[gi]    = en & ~reset & cs[gi] & wr[gi] & in_range[gi];
      assign rd_ok[gi]    = en & ~reset & cs[gi] & ~wr[gi];
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // s2 is applied first so that s1 overrides it on any lane both ports enable.
  always_ff @(posedge clk) begin
    for (int p = NP - 1; p >= 0; p--) begin
      if (wr_ok[p]) begin
        for (int b = 0; b < NB; b++) begin
          if (be[p][b]) mem[addr[p]][8*b +: 8] <= wdata[p][8*b +: 8];
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NP; gi++) begin : g_port
      localparam int OTHER = NP - 1 - gi;

      logic                  fwd_hit;
      logic [DATA_WIDTH-1:0] ram_q_reg;
      logic                  valid0_reg, oob0_reg;
      logic [NB-1:0]         fwd_be_reg;
      logic [DATA_WIDTH-1:0] fwd_data_reg;
      logic [DATA_WIDTH-1:0] merged_next;
      logic                  valid1_reg;
      logic [DATA_WIDTH-1:0] data1_reg;
      logic                  valid_out;
      logic [DATA_WIDTH-1:0] data_out;

      assign fwd_hit = wr_ok[OTHER] && (addr[OTHER] == addr[gi]);

      // Array read stays reset-free so it maps onto the block RAM output register.
      always_ff @(posedge clk) begin
        if (rd_ok[gi] && in_range[gi]) ram_q_reg <= mem[addr[gi]];
        if (reset) begin
          valid0_reg   <= 1'b0;
          oob0_reg     <= 1'b0;
          fwd_be_reg   <= '0;
          fwd_data_reg <= '0;
        end else if (en) begin
          valid0_reg   <= rd_ok[gi];
          oob0_reg     <= ~in_range[gi];
          fwd_be_reg   <= fwd_hit ? be[OTHER] : '0;
          fwd_data_reg <= wdata[OTHER];
        end
      end

      // The array returns pre-write contents; overlay the other port's same-cycle write.
      always_comb begin
        merged_next = ram_q_reg;
        for (int b = 0; b < NB; b++) begin
          if (fwd_be_reg[b]) merged_next[8*b +: 8] = fwd_data_reg[8*b +: 8];
        end
        if (oob0_reg) merged_next = '0;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          valid1_reg <= 1'b0;
          data1_reg  <= '0;
        end else if (en) begin
          valid1_reg <= valid0_reg;
          data1_reg  <= merged_next;
        end
      end

      if (OUTPUT_REG != 0) begin : g_oreg
        logic                  valid2_reg;
        logic [DATA_WIDTH-1:0] data2_reg;

        always_ff @(posedge clk) begin
          if (reset) begin
            valid2_reg <= 1'b0;
            data2_reg  <= '0;
          end else if (en) begin
            valid2_reg <= valid1_reg;
            data2_reg  <= data1_reg;
          end
        end

        assign valid_out = valid2_reg;
        assign data_out  = data2_reg;
      end else begin : g_noreg
        assign valid_out = valid1_reg;
        assign data_out  = data1_reg;
      end

      // A held result is masked during a stall and shows exactly once when en returns.
      assign rvalid[gi] = valid_out & en;
      assign rdata[gi]  = data_out;
    end
  endgenerate

endmodule

// File: tb/tb_onchip_memory_dp.sv
// Bench for onchip_memory_dp: OUTPUT_REG=0 and OUTPUT_REG=1 instances driven in lockstep,
// read results checked against a queue of expected words filled at issue time.
module tb_onchip_memory_dp;
  localparam int DW    = 32;
  localparam int AW    = 15;
  localparam int DEPTH = 32000;

  typedef struct {
    int          sid;   // 2*instance + port
    logic [31:0] data;
    int          due;   // observation cycle, -1 when not timed
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, clken, reset_req;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_write, s2_chipselect, s2_write;
  logic [3:0]    s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata;
  logic          wreq [4];
  logic [DW-1:0] rd   [4];
  logic          rv   [4];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      onchip_memory_dp #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .OUTPUT_REG(gi), .INIT_FILE("onchip_memory_dp.hex")
      ) dut (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_waitrequest(wreq[2*gi]), .s1_readdata(rd[2*gi]), .s1_readdatavalid(rv[2*gi]),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_write(s2_write),
        .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_waitrequest(wreq[2*gi+1]), .s2_readdata(rd[2*gi+1]), .s2_readdatavalid(rv[2*gi+1])
      );
    end
  endgenerate

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          no_lat = 1'b0;
  bit          no_push = 1'b0;
  exp_t        exp_q[$];
  logic [31:0] mdl [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: waitrequest every cycle, and each readdatavalid against the scoreboard.
  always @(negedge clk) begin
    for (int s = 0; s < 4; s++) begin
      int idx;
      idx = -1;
      check($sformatf("waitreq_%0d", s), 32'(wreq[s]), 32'(!(clken && !reset_req)));
      if (rv[s]) begin
        for (int i = 0; i < exp_q.size(); i++) begin
          if (exp_q[i].sid == s) begin
            idx = i;
            break;
          end
        end
        if (idx < 0) begin
          check($sformatf("spurious_valid_%0d", s), 32'(rv[s]), 32'd0);
        end else begin
          $display("read stream %0d data %h expected %h", s, rd[s], exp_q[idx].data);
          check($sformatf("rdata_%0d", s), rd[s], exp_q[idx].data);
          if (exp_q[idx].due >= 0)
            check($sformatf("latency_%0d", s), 32'(cyc), 32'(exp_q[idx].due));
          exp_q.delete(idx);
        end
      end
    end
  end

  task automatic model_write(input int a, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (be[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic push_read(input int port, input int a);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      e.sid  = 2 * d + port;
      e.data = (a < DEPTH) ? mdl[a] : 32'd0;
      e.due  = no_lat ? -1 : cyc + 2 + d;
      exp_q.push_back(e);
    end
  endtask

  // One bus cycle on both ports; the model takes writes first (s1 last, so it wins)
  // and readers then see the post-write contents.
  task automatic drive(input bit cs1, input bit w1, input int a1, input logic [3:0] be1,
                       input logic [31:0] wd1, input bit cs2, input bit w2, input int a2,
                       input logic [3:0] be2, input logic [31:0] wd2);
    s1_chipselect = cs1; s1_write = w1; s1_address = AW'(a1);
    s1_byteenable = be1; s1_writedata = wd1;
    s2_chipselect = cs2; s2_write = w2; s2_address = AW'(a2);
    s2_byteenable = be2; s2_writedata = wd2;
    if (clken && !reset_req && !reset) begin
      if (cs2 && w2 && a2 < DEPTH) model_write(a2, be2, wd2);
      if (cs1 && w1 && a1 < DEPTH) model_write(a1, be1, wd1);
      if (!no_push && cs1 && !w1) push_read(0, a1);
      if (!no_push && cs2 && !w2) push_read(1, a2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 4'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
  endtask

  task automatic wr1(input int a, input logic [3:0] be, input logic [31:0] d);
    drive(1, 1, a, be, d, 0, 0, 0, 4'h0, 32'h0);
  endtask

  task automatic rd1(input int a);
    drive(1, 0, a, 4'h0, 32'h0, 0, 0, 0, 4'h0, 32'h0);
  endtask

  task automatic rd2(input int a);
    drive(0, 0, 0, 4'h0, 32'h0, 1, 0, a, 4'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
    s1_address = '0; s1_chipselect = 0; s1_write = 0; s1_byteenable = '0; s1_writedata = '0;
    s2_address = '0; s2_chipselect = 0; s2_write = 0; s2_byteenable = '0; s2_writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("reset_rdata_%0d", s), rd[s], 32'd0);
      check($sformatf("reset_valid_%0d", s), 32'(rv[s]), 32'd0);
    end

    // Basic write then read, timed
    wr1(5, 4'hF, 32'h12345678);
    rd1(5);
    idle(3);

    // Byte enables
    wr1(7, 4'hF, 32'hFFFFFFFF);
    wr1(7, 4'h1, 32'h000000AA);
    rd2(7);
    idle(3);

    // Same-cycle double write, full lanes then partial s1 lanes
    drive(1, 1, 9, 4'hF, 32'h11111111, 1, 1, 9, 4'hF, 32'h22222222);
    rd1(9);
    drive(1, 1, 9, 4'h3, 32'h11111111, 1, 1, 9, 4'hF, 32'h22222222);
    rd2(9);
    idle(3);

    // Cross-port forwarding with byte merge
    wr1(3, 4'hF, 32'hDEADBEEF);
    drive(1, 1, 3, 4'h3, 32'h0000CAFE, 1, 0, 3, 4'h0, 32'h0);
    // Both ports read the same word
    drive(1, 0, 5, 4'h0, 32'h0, 1, 0, 5, 4'h0, 32'h0);
    idle(3);

    // Back-to-back reads with a 3-cycle clken stall; a write offered during the stall is dropped
    no_lat = 1'b1;
    rd1(5);
    rd1(7);
    clken = 1'b0;
    repeat (3) drive(1, 0, 9, 4'h0, 32'h0, 1, 1, 5, 4'hF, 32'hBADBAD00);
    clken = 1'b1;
    rd1(9);
    rd1(3);
    reset_req = 1'b1;
    drive(0, 0, 0, 4'h0, 32'h0, 1, 1, 5, 4'hF, 32'hBADBAD01);
    reset_req = 1'b0;
    no_lat = 1'b0;
    idle(3);
    rd2(5);
    idle(3);

    // Out of range: reads give zero, writes change nothing and do not wrap
    wr1(1, 4'hF, 32'h55555555);
    rd1(DEPTH);
    wr1(DEPTH + 1, 4'hF, 32'hBADC0DE5);
    rd2(DEPTH + 1);
    rd1(1);
    idle(4);

    // Reset while reads are in flight
    no_push = 1'b1;
    drive(1, 0, 5, 4'h0, 32'h0, 1, 0, 7, 4'h0, 32'h0);
    no_push = 1'b0;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("midreset_rdata_%0d", s), rd[s], 32'd0);
      check($sformatf("midreset_valid_%0d", s), 32'(rv[s]), 32'd0);
    end
    idle(3);
    drive(1, 0, 7, 4'h0, 32'h0, 1, 0, 5, 4'h0, 32'h0);
    idle(3);

    // Random traffic over a small preloaded window, with occasional stalls
    for (int a = 0; a < 8; a++)
      drive(1, 1, a, 4'hF, $urandom, 1, 1, a + 8, 4'hF, $urandom);
    idle(3);
    no_lat = 1'b1;
    for (int i = 0; i < 80; i++) begin
      clken = ($urandom_range(0, 7) != 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
            4'($urandom), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
            4'($urandom), $urandom);
    end
    clken = 1'b1;
    no_lat = 1'b0;

    for (int i = 0; i < 30 && exp_q.size() > 0; i++) idle(1);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/onchip_memory_dp.md
Name: onchip_memory_dp

Overview:
- Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2) on one clock.
- Successor to the single-port on-chip memory. Adds configurable width, depth and read latency.
- Adds pipelined reads with readdatavalid, cross-port write forwarding, a defined collision policy and out-of-range address handling.
- Sits on the Nios II data/instruction interconnect as program/data memory shared by two masters.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8
ADDR_WIDTH, 15, word-address width of each port
DEPTH, 32000, number of words; must be <= 2**ADDR_WIDTH
OUTPUT_REG, 0, 0: read latency 1 cycle; 1: extra output register, latency 2
INIT_FILE, "onchip_memory_dp.hex", initial contents (simulation/synthesis init only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
clken  in  1  global clock enable; 0 freezes both ports
reset_req  in  1  reset-request guard; 1 behaves as clken=0
s1_address  in  ADDR_WIDTH  port 1 word address
s1_chipselect  in  1  port 1 select
s1_write  in  1  port 1 write strobe (read when chipselect & ~write)
s1_byteenable  in  DATA_WIDTH/8  port 1 byte lanes
s1_writedata  in  DATA_WIDTH  port 1 write data
s1_waitrequest  out  1  port 1 stall
s1_readdata  out  DATA_WIDTH  port 1 read data
s1_readdatavalid  out  1  port 1 read data valid
s2_* (address, chipselect, write, byteenable, writedata, waitrequest, readdata, readdatavalid)  same widths/directions as s1

Behaviour:
- en = clken & ~reset_req. Both ports present waitrequest = ~en combinationally. A command is accepted only when chipselect & en.
- Reset (sync, reset=1 at posedge):
  - readdata=0 and readdatavalid=0 on both ports; pipeline flushed.
  - RAM contents are NOT cleared.
  - Any command presented in the reset cycle is dropped.
- Write:
  - Lanes with byteenable=1 update at the accepting edge. Byteenable=0 is a no-op.
  - No response is generated for writes.
- Read:
  - Accepted at edge N. readdata/readdatavalid are asserted for exactly one cycle after edge N+1+OUTPUT_REG.
  - Back-to-back reads give one result per cycle, in order.
- Stall: while en=0 the read pipeline holds its state. readdatavalid is held at 0 and in-flight data resumes when en returns.
- Same-port read-during-write: not possible, since a cycle is either a read or a write.
- Cross-port, same address, same cycle, one read and one write: the reader gets the NEW data (forwarded, with byte merge per the writer's byteenable).
- Cross-port, both write the same address in the same cycle: s1 wins on every lane s1 enables. s2 lanes not enabled by s1 are still written.
- Both ports read the same address: both get identical data at the same latency.
- Out-of-range (address >= DEPTH):
  - Writes are ignored.
  - Reads return 0 with a normal readdatavalid.
  - No wrap-around.
- Widths: the byteenable index i maps to bits [8i+7:8i]. Address is a word address, not a byte address.
- Reset has priority over en. Reset asserted while reads are in flight discards them, and no readdatavalid follows.

Test Plan:
- Basic R/W, OUTPUT_REG=0:
  - s1 write 0x12345678 to addr 5, then s1 read addr 5 -> readdatavalid 1 cycle after accept, readdata=0x12345678.
  - Repeat with OUTPUT_REG=1 -> valid 2 cycles after accept.
- Byte enables: write 0xFFFFFFFF to addr 7, then write 0x000000AA with byteenable=0001 -> s2 read addr 7 returns 0xFFFFFFAA.
- Collision:
  - Same cycle: s1 writes 0x11111111 (be=1111) and s2 writes 0x22222222 (be=1111) to addr 9 -> read gives 0x11111111.
  - With s1 be=0011 -> read gives 0x22221111.
- Forwarding:
  - addr 3 holds 0xDEADBEEF. Same cycle: s1 writes 0x0000CAFE (be=0011) and s2 reads addr 3 -> s2 readdata=0xDEADCAFE.
- Stall/out-of-range:
  - Issue 4 back-to-back reads, drop clken for 3 cycles mid-stream -> waitrequest=1 during the stall; 4 valids in order with no duplicates.
  - Read addr 32000 -> readdata=0, valid asserted.
  - Write addr 32001 -> no RAM change.
- Reset mid-operation: issue reads on both ports, assert reset on the next edge -> no readdatavalid, readdata=0; previously written contents still readable after reset.
